// File: rtl/input_buffer_pkg.sv
// input_buffer_pkg
//   Shared types and sizing helpers for the multichannel input buffer.
//   sink_state_t : capture-side FSM states (sink_clk domain)
//   src_state_t  : replay-side FSM states (source_clk domain)
//   tot_size     : entries stored per channel for one capture
//   clog2_min1   : address/select width that never collapses to zero
package input_buffer_pkg;

   typedef enum logic [1:0] {SinkIdle, SinkCapture, SinkWait} sink_state_t;
   typedef enum logic       {SrcIdle, SrcPlay} src_state_t;

   function automatic int unsigned tot_size(int unsigned batch, int unsigned runs,
                                            int unsigned stride);
      return batch + (runs - 1) * stride;
   endfunction

   function automatic int unsigned clog2_min1(int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/dp_ram_1r1w.sv
// dp_ram_1r1w
//   Simple dual-clock RAM, one write port and one registered read port.
//   Storage is not reset.
//   wr_clk_i/wr_en_i/wr_addr_i/wr_data_i : write port (write clock domain)
//   rd_clk_i/rd_en_i/rd_addr_i           : read request (read clock domain)
//   rd_data_o                            : read data, valid one rd_clk_i edge after rd_en_i
module dp_ram_1r1w #(
   parameter int unsigned Width     = 8,
   parameter int unsigned Depth     = 16,
   parameter int unsigned AddrWidth = 4
) (
   input  logic                 wr_clk_i,
   input  logic                 wr_en_i,
   input  logic [AddrWidth-1:0] wr_addr_i,
   input  logic [Width-1:0]     wr_data_i,
   input  logic                 rd_clk_i,
   input  logic                 rd_en_i,
   input  logic [AddrWidth-1:0] rd_addr_i,
   output logic [Width-1:0]     rd_data_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] rd_data_q;

   always_ff @(posedge wr_clk_i) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
   end

   always_ff @(posedge rd_clk_i) begin
      if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/multichannel_input_buffer.sv
// multichannel_input_buffer
//   Captures a snapshot of CHANNELS parallel sample streams on sink_clk and replays it on
//   source_clk as RUNS overlapping batches per channel (start offset steps by STRIDE), as an
//   Avalon-ST source with ready latency 0.
//   sink_clk, reset, start, sink_data, busy          : capture side (sink_clk domain)
//   source_clk, source_ready, source_valid, source_sop, source_eop,
//   source_channel, source_data                      : replay side (source_clk domain)
module multichannel_input_buffer
   import input_buffer_pkg::*;
#(
   parameter int unsigned BATCH_SIZE = 2048,
   parameter int unsigned RUNS       = 3,
   parameter int unsigned STRIDE     = 1,
   parameter int unsigned CHANNELS   = 2,
   parameter int unsigned DATA_WIDTH = 14
) (
   input  logic                                 sink_clk,
   input  logic                                 reset,
   input  logic                                 source_clk,
   input  logic                                 start,
   input  logic [CHANNELS*DATA_WIDTH-1:0]       sink_data,
   output logic                                 busy,
   input  logic                                 source_ready,
   output logic                                 source_valid,
   output logic                                 source_sop,
   output logic                                 source_eop,
   output logic [clog2_min1(CHANNELS)-1:0]      source_channel,
   output logic [DATA_WIDTH-1:0]                source_data
);

   localparam int unsigned TotSize = tot_size(BATCH_SIZE, RUNS, STRIDE);
   localparam int unsigned AW      = clog2_min1(TotSize);
   localparam int unsigned WpW     = $clog2(TotSize + 1);
   localparam int unsigned IdxW    = $clog2(BATCH_SIZE + 1);
   localparam int unsigned RunW    = $clog2(RUNS + 1);
   localparam int unsigned ChW     = clog2_min1(CHANNELS);

   localparam logic [WpW-1:0]  WpLast  = WpW'(TotSize - 1);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(BATCH_SIZE - 1);
   localparam logic [RunW-1:0] RunLast = RunW'(RUNS - 1);
   localparam logic [ChW-1:0]  ChLast  = ChW'(CHANNELS - 1);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  sop;
      logic                  eop;
      logic                  last;
      logic [ChW-1:0]        ch;
   } entry_t;

   // ---------------- sink_clk domain ----------------
   sink_state_t    sink_q, sink_d;
   logic           busy_q, busy_d;
   logic [WpW-1:0] wp_q, wp_d;
   logic           cap_tgl_q, cap_tgl_d;
   logic           rep_s1_q, rep_s2_q, rep_s3_q;
   logic           wr_en;
   logic           rep_tgl_q;

   always_comb begin
      sink_d    = sink_q;
      busy_d    = busy_q;
      wp_d      = wp_q;
      cap_tgl_d = cap_tgl_q;
      wr_en     = 1'b0;
      unique case (sink_q)
         SinkIdle: begin
            if (start) begin
               sink_d = SinkCapture;
               busy_d = 1'b1;
               wp_d   = '0;
            end
         end
         SinkCapture: begin
            wr_en = 1'b1;
            if (wp_q == WpLast) begin
               cap_tgl_d = ~cap_tgl_q;
               sink_d    = SinkWait;
            end else begin
               wp_d = wp_q + 1'b1;
            end
         end
         SinkWait: begin
            // Replay side signals completion by toggling; any change ends the wait.
            if (rep_s2_q ^ rep_s3_q) begin
               sink_d = SinkIdle;
               busy_d = 1'b0;
            end
         end
         default: sink_d = SinkIdle;
      endcase
   end

   always_ff @(posedge sink_clk) begin
      if (reset) begin
         sink_q    <= SinkIdle;
         busy_q    <= 1'b0;
         wp_q      <= '0;
         cap_tgl_q <= 1'b0;
         rep_s1_q  <= 1'b0;
         rep_s2_q  <= 1'b0;
         rep_s3_q  <= 1'b0;
      end else begin
         sink_q    <= sink_d;
         busy_q    <= busy_d;
         wp_q      <= wp_d;
         cap_tgl_q <= cap_tgl_d;
         rep_s1_q  <= rep_tgl_q;
         rep_s2_q  <= rep_s1_q;
         rep_s3_q  <= rep_s2_q;
      end
   end

   assign busy = busy_q;

   // ---------------- storage ----------------
   logic                           rd_en;
   logic [AW-1:0]                  rd_addr;
   logic [CHANNELS*DATA_WIDTH-1:0] ram_rdata;

   dp_ram_1r1w #(
      .Width     (CHANNELS * DATA_WIDTH),
      .Depth     (TotSize),
      .AddrWidth (AW)
   ) u_ram (
      .wr_clk_i  (sink_clk),
      .wr_en_i   (wr_en),
      .wr_addr_i (AW'(wp_q)),
      .wr_data_i (sink_data),
      .rd_clk_i  (source_clk),
      .rd_en_i   (rd_en),
      .rd_addr_i (rd_addr),
      .rd_data_o (ram_rdata)
   );

   // ---------------- source_clk domain ----------------
   logic rst_s1_q, rst_s2_q;

   always_ff @(posedge source_clk) begin
      rst_s1_q <= reset;
      rst_s2_q <= rst_s1_q;
   end

   src_state_t      src_q, src_d;
   logic [RunW-1:0] run_q, run_d;
   logic [ChW-1:0]  ch_q, ch_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [AW-1:0]   base_q, base_d;
   logic            issue_done_q, issue_done_d;
   logic            rep_tgl_d;
   logic            cap_s1_q, cap_s2_q, cap_s3_q;
   logic            rd_vld_q;
   entry_t          rd_meta_q, rd_meta_d;
   entry_t          slot_q [2];
   entry_t          slot_d [2];
   logic [1:0]      cnt_q, cnt_d;
   logic            pop, issue, done;
   logic [2:0]      occ;
   entry_t          push_entry;

   always_comb begin
      src_d        = src_q;
      run_d        = run_q;
      ch_d         = ch_q;
      idx_d        = idx_q;
      base_d       = base_q;
      issue_done_d = issue_done_q;
      rep_tgl_d    = rep_tgl_q;
      slot_d       = slot_q;
      cnt_d        = cnt_q;
      rd_meta_d    = rd_meta_q;

      pop  = (cnt_q != 2'd0) && source_ready;
      done = pop && slot_q[0].last;
      // Reads in flight count against the 2-entry skid so it can never overflow.
      occ   = 3'(cnt_q) + 3'(rd_vld_q);
      issue = (src_q == SrcPlay) && !issue_done_q && (occ < (3'd2 + 3'(pop)));
      rd_en   = issue;
      rd_addr = base_q + AW'(idx_q);

      push_entry      = rd_meta_q;
      push_entry.data = ram_rdata[int'(rd_meta_q.ch) * DATA_WIDTH +: DATA_WIDTH];

      if (issue) begin
         rd_meta_d.data = '0;
         rd_meta_d.sop  = (idx_q == '0);
         rd_meta_d.eop  = (idx_q == IdxLast);
         rd_meta_d.last = (idx_q == IdxLast) && (ch_q == ChLast) && (run_q == RunLast);
         rd_meta_d.ch   = ch_q;
         if (rd_meta_d.last) issue_done_d = 1'b1;
         if (idx_q == IdxLast) begin
            idx_d = '0;
            if (ch_q == ChLast) begin
               ch_d   = '0;
               run_d  = run_q + 1'b1;
               base_d = base_q + AW'(STRIDE);
            end else begin
               ch_d = ch_q + 1'b1;
            end
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end

      if (pop) begin
         slot_d[0] = slot_q[1];
         cnt_d     = cnt_q - 1'b1;
      end
      if (rd_vld_q) begin
         slot_d[cnt_d[0]] = push_entry;
         cnt_d            = cnt_d + 1'b1;
      end

      unique case (src_q)
         SrcIdle: begin
            if (cap_s2_q ^ cap_s3_q) begin
               src_d        = SrcPlay;
               run_d        = '0;
               ch_d         = '0;
               idx_d        = '0;
               base_d       = '0;
               issue_done_d = 1'b0;
            end
         end
         SrcPlay: begin
            if (done) begin
               src_d     = SrcIdle;
               rep_tgl_d = ~rep_tgl_q;
            end
         end
         default: src_d = SrcIdle;
      endcase
   end

   always_ff @(posedge source_clk) begin
      if (rst_s2_q) begin
         src_q        <= SrcIdle;
         run_q        <= '0;
         ch_q         <= '0;
         idx_q        <= '0;
         base_q       <= '0;
         issue_done_q <= 1'b0;
         rep_tgl_q    <= 1'b0;
         cap_s1_q     <= 1'b0;
         cap_s2_q     <= 1'b0;
         cap_s3_q     <= 1'b0;
         rd_vld_q     <= 1'b0;
         rd_meta_q    <= '0;
         slot_q[0]    <= '0;
         slot_q[1]    <= '0;
         cnt_q        <= '0;
      end else begin
         src_q        <= src_d;
         run_q        <= run_d;
         ch_q         <= ch_d;
         idx_q        <= idx_d;
         base_q       <= base_d;
         issue_done_q <= issue_done_d;
         rep_tgl_q    <= rep_tgl_d;
         cap_s1_q     <= cap_tgl_q;
         cap_s2_q     <= cap_s1_q;
         cap_s3_q     <= cap_s2_q;
         rd_vld_q     <= issue;
         rd_meta_q    <= rd_meta_d;
         slot_q       <= slot_d;
         cnt_q        <= cnt_d;
      end
   end

   assign source_valid   = (cnt_q != 2'd0);
   assign source_sop     = slot_q[0].sop;
   assign source_eop     = slot_q[0].eop;
   assign source_channel = slot_q[0].ch;
   assign source_data    = slot_q[0].data;

endmodule

// File: tb/tb_multichannel_input_buffer.sv
// tb_multichannel_input_buffer
//   Self-checking bench: main instance (B=8, R=3, S=2, C=2) and an edge instance
//   (B=2, R=1, C=1). Expected replay order comes from a queue built from the batch rules.
`timescale 1ns/100ps
module tb_multichannel_input_buffer;

   localparam int B = 8, R = 3, S = 2, C = 2, DW = 14;
   localparam int TOT = B + (R - 1) * S;
   localparam int NX = R * C * B;

   logic sink_clk = 1'b0, source_clk = 1'b0;
   logic reset = 1'b1, start = 1'b0, start2 = 1'b0;
   logic ready = 1'b1;
   logic ready2 = 1'b1;
   logic [C*DW-1:0] sink_data;
   logic [DW-1:0] sink_data2;
   logic busy, valid, sop, eop;
   logic [0:0] chan;
   logic [DW-1:0] data;
   logic busy2, valid2, sop2, eop2;
   logic [0:0] chan2;
   logic [DW-1:0] data2;

   realtime src_half = 6.85;
   always #5 sink_clk = ~sink_clk;
   always #(src_half) source_clk = ~source_clk;

   multichannel_input_buffer #(
      .BATCH_SIZE(B), .RUNS(R), .STRIDE(S), .CHANNELS(C), .DATA_WIDTH(DW)
   ) dut (
      .sink_clk(sink_clk), .reset(reset), .source_clk(source_clk), .start(start),
      .sink_data(sink_data), .busy(busy), .source_ready(ready), .source_valid(valid),
      .source_sop(sop), .source_eop(eop), .source_channel(chan), .source_data(data)
   );

   multichannel_input_buffer #(
      .BATCH_SIZE(2), .RUNS(1), .STRIDE(1), .CHANNELS(1), .DATA_WIDTH(DW)
   ) dut_edge (
      .sink_clk(sink_clk), .reset(reset), .source_clk(source_clk), .start(start2),
      .sink_data(sink_data2), .busy(busy2), .source_ready(ready2), .source_valid(valid2),
      .source_sop(sop2), .source_eop(eop2), .source_channel(chan2), .source_data(data2)
   );

   // Sample generator: sample n of an accepted capture reads gen_base + n (ch1 adds 100).
   int samp = 0;
   int gen_base = 0;
   logic st_d = 1'b0;
   always @(posedge sink_clk) st_d <= (start && !busy) || (start2 && !busy2);
   always @(negedge sink_clk) samp <= st_d ? 0 : samp + 1;
   assign sink_data  = {DW'(gen_base + 100 + samp), DW'(gen_base + samp)};
   assign sink_data2 = DW'(gen_base + samp);

   int n_checks = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   typedef struct {
      int data;
      bit sop;
      bit eop;
      int ch;
   } exp_t;
   exp_t q[$];

   task automatic fill_exp(input int base);
      exp_t e;
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++)
            for (int i = 0; i < B; i++) begin
               e.data = base + c * 100 + r * S + i;
               e.sop  = (i == 0);
               e.eop  = (i == B - 1);
               e.ch   = c;
               q.push_back(e);
            end
   endtask

   // Ready generator and transfer monitor.
   bit bp_mode = 0;
   always @(posedge source_clk) begin
      #1 ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   int xfer_cnt = 0;
   bit mon_en = 0;
   bit hold_pending = 0;
   logic [DW-1:0] h_data;
   logic h_sop, h_eop;
   logic [0:0] h_chan;
   always @(negedge source_clk) begin
      if (mon_en) begin
         if (hold_pending) begin
            chk("hold_valid", 32'(valid), 32'd1);
            chk("hold_data", 32'(data), 32'(h_data));
            chk("hold_sop", 32'(sop), 32'(h_sop));
            chk("hold_eop", 32'(eop), 32'(h_eop));
            chk("hold_chan", 32'(chan), 32'(h_chan));
         end
         hold_pending = 0;
         if (valid && ready) begin
            if (q.size() != 0) begin
               exp_t e;
               e = q.pop_front();
               chk("xfer_data", 32'(data), 32'(e.data));
               chk("xfer_sop", 32'(sop), 32'(e.sop));
               chk("xfer_eop", 32'(eop), 32'(e.eop));
               chk("xfer_chan", 32'(chan), 32'(e.ch));
            end
            xfer_cnt++;
         end else if (valid) begin
            hold_pending = 1;
            h_data = data; h_sop = sop; h_eop = eop; h_chan = chan;
         end
      end else begin
         hold_pending = 0;
      end
   end

   task automatic pulse_start();
      @(posedge sink_clk); #1 start = 1'b1;
      @(posedge sink_clk); #1 start = 1'b0;
   endtask

   // Start a capture, watch the capture window, optionally poke ignored starts.
   task automatic begin_capture(input int base, input bit rearm);
      gen_base = base;
      fill_exp(base);
      xfer_cnt = 0;
      pulse_start();
      chk("busy_after_start", 32'(busy), 32'd1);
      for (int i = 0; i < TOT; i++) begin
         @(posedge sink_clk); #1;
         chk("no_valid_during_capture", 32'(valid), 32'd0);
         if (rearm) start = (i == 3);
      end
      start = 1'b0;
      if (rearm) begin
         repeat (8) @(posedge sink_clk);
         #1 chk("busy_in_wait", 32'(busy), 32'd1);
         pulse_start();
      end
   endtask

   task automatic finish_capture();
      int t = 0;
      while ((q.size() != 0 || busy) && t < 5000) begin
         @(posedge sink_clk); #1;
         t++;
      end
      chk("drained_and_idle", 32'(q.size() == 0 && !busy), 32'd1);
      repeat (10) @(posedge sink_clk);
      #1;
      chk("xfer_count", 32'(xfer_cnt), 32'(NX));
      chk("valid_idle", 32'(valid), 32'd0);
      chk("busy_low", 32'(busy), 32'd0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t;
      repeat (10) @(posedge sink_clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_sop", 32'(sop), 32'd0);
      chk("rst_eop", 32'(eop), 32'd0);
      chk("rst_chan", 32'(chan), 32'd0);
      chk("rst_data", 32'(data), 32'd0);
      chk("rst_busy2", 32'(busy2), 32'd0);
      chk("rst_valid2", 32'(valid2), 32'd0);
      reset = 1'b0;
      repeat (5) @(posedge sink_clk);
      mon_en = 1;

      // Basic replay, ready held high.
      begin_capture(0, 0);
      finish_capture();

      // Random backpressure.
      bp_mode = 1;
      begin_capture(0, 0);
      finish_capture();
      bp_mode = 0;

      // Starts during CAPTURE and WAIT are ignored; a later start captures fresh samples.
      begin_capture(0, 1);
      finish_capture();
      begin_capture(50, 0);
      finish_capture();

      // Reset in the middle of a replay.
      begin_capture(0, 0);
      t = 0;
      while (xfer_cnt < 20 && t < 2000) begin
         @(posedge sink_clk); #1;
         t++;
      end
      chk("reached_20_xfers", 32'(xfer_cnt >= 20), 32'd1);
      mon_en = 0;
      reset = 1'b1;
      repeat (3) @(posedge source_clk);
      #1 chk("valid_low_after_reset", 32'(valid), 32'd0);
      repeat (6) @(posedge sink_clk);
      #1 chk("busy_low_after_reset", 32'(busy), 32'd0);
      reset = 1'b0;
      q.delete();
      repeat (5) @(posedge sink_clk);
      mon_en = 1;
      begin_capture(0, 0);
      finish_capture();

      // Edge parameters: one channel, one run, two-entry batch.
      gen_base = 0;
      @(posedge sink_clk); #1 start2 = 1'b1;
      @(posedge sink_clk); #1 start2 = 1'b0;
      chk("edge_busy", 32'(busy2), 32'd1);
      t = 0;
      while (!valid2 && t < 200) begin
         @(negedge source_clk);
         t++;
      end
      chk("edge_valid_seen", 32'(valid2), 32'd1);
      chk("edge_d0", 32'(data2), 32'd0);
      chk("edge_sop0", 32'(sop2), 32'd1);
      chk("edge_eop0", 32'(eop2), 32'd0);
      chk("edge_chan0", 32'(chan2), 32'd0);
      @(negedge source_clk);
      chk("edge_d1", 32'(data2), 32'd1);
      chk("edge_valid1", 32'(valid2), 32'd1);
      chk("edge_sop1", 32'(sop2), 32'd0);
      chk("edge_eop1", 32'(eop2), 32'd1);
      @(negedge source_clk);
      chk("edge_idle", 32'(valid2), 32'd0);
      t = 0;
      while (busy2 && t < 200) begin
         @(posedge sink_clk); #1;
         t++;
      end
      chk("edge_busy_low", 32'(busy2), 32'd0);

      // Clock ratios: source 3x faster, then 3x slower than sink.
      src_half = 5.0 / 3.0;
      repeat (5) @(posedge sink_clk);
      begin_capture(0, 0);
      finish_capture();
      src_half = 15.0;
      repeat (5) @(posedge sink_clk);
      bp_mode = 1;
      begin_capture(0, 0);
      finish_capture();
      bp_mode = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
